// File: rtl/ga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ga_pkg
// Description : Shared constants, FSM state type and width helper for the
//               GA fitness datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package ga_pkg;

    localparam int C_SUM_W = 5;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Total width large enough that (2^sum_w-1)*count cannot overflow.
    function automatic int acc_width(input int sum_w, input int count);
        return sum_w + $clog2(count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/max_tracker.sv
`default_nettype none
// ============================================================================
// Module      : max_tracker
// Description : Next-value logic for a running maximum and the index of its
//               first occurrence (strictly-greater replaces, ties keep old).
// Revision    : 1.0 - initial release
// ============================================================================
module max_tracker #(
    parameter int SUM_W = 5,
    parameter int IDX_W = 3
)(
    input  logic             first,
    input  logic [SUM_W-1:0] sample,
    input  logic [IDX_W-1:0] idx,
    input  logic [SUM_W-1:0] cur_max,
    input  logic [IDX_W-1:0] cur_idx,
    output logic [SUM_W-1:0] nxt_max,
    output logic [IDX_W-1:0] nxt_idx
);

    logic w_take;

    assign w_take  = first || (sample > cur_max);
    assign nxt_max = w_take ? sample : cur_max;
    assign nxt_idx = w_take ? idx    : cur_idx;

endmodule
`default_nettype wire

// File: rtl/fitness_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fitness_accumulator
// Description : Accumulates a batch of COUNT adder sums, tracks the max and
//               its first index, and holds the result on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module fitness_accumulator
    import ga_pkg::*;
#(
    parameter int SUM_W = C_SUM_W,
    parameter int COUNT = 8,
    parameter int IDX_W = $clog2(COUNT),
    parameter int ACC_W = acc_width(SUM_W, COUNT)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [SUM_W-1:0] out_max,
    output logic [IDX_W-1:0] out_max_idx
);

    localparam logic [IDX_W-1:0] c_LAST    = IDX_W'(COUNT - 1);
    localparam logic [IDX_W-1:0] c_CNT_ONE = IDX_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_total;
    logic [SUM_W-1:0]   r_max;
    logic [IDX_W-1:0]   r_max_idx;
    logic               w_accept;
    logic               w_release;
    logic               w_last;
    logic [SUM_W-1:0]   w_max_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush overrides everything, including a same-cycle accept.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready && !flush) begin
                    w_release   = 1'b1;
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
        if (flush) begin
            w_state_nxt = ACCUM;
        end
    end

    max_tracker #(
        .SUM_W (SUM_W),
        .IDX_W (IDX_W)
    ) u_max_tracker (
        .first   (r_cnt == '0),
        .sample  (in_sum),
        .idx     (r_cnt),
        .cur_max (r_max),
        .cur_idx (r_max_idx),
        .nxt_max (w_max_nxt),
        .nxt_idx (w_idx_nxt)
    );

    // The accumulators double as the result registers while in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_total   <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
        end else if (flush) begin
            r_cnt     <= '0;
            r_total   <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
        end else if (w_accept) begin
            r_cnt     <= w_last ? '0 : (r_cnt + c_CNT_ONE);
            r_total   <= r_total + ACC_W'(in_sum);
            r_max     <= w_max_nxt;
            r_max_idx <= w_idx_nxt;
        end else if (w_release) begin
            r_total   <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
        end
    end

    assign out_total   = r_total;
    assign out_max     = r_max;
    assign out_max_idx = r_max_idx;

endmodule
`default_nettype wire

// File: tb/tb_fitness_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fitness_accumulator
// Description : Directed and randomized checks of fitness_accumulator against
//               a batch-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fitness_accumulator;

    localparam int SUM_W = 5;
    localparam int COUNT = 8;
    localparam int IDX_W = 3;
    localparam int ACC_W = 8;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_total;
    logic [SUM_W-1:0] out_max;
    logic [IDX_W-1:0] out_max_idx;

    fitness_accumulator #(
        .SUM_W (SUM_W),
        .COUNT (COUNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_total   (out_total),
        .out_max     (out_max),
        .out_max_idx (out_max_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of accepted samples plus the pending result.
    int q[$];
    bit m_hold;
    int m_total;
    int m_max;
    int m_idx;
    int batches;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic finish_batch();
        m_total = 0;
        m_max   = -1;
        m_idx   = 0;
        foreach (q[i]) begin
            m_total += q[i];
            if (q[i] > m_max) begin
                m_max = q[i];
                m_idx = i;
            end
        end
        q.delete();
        m_hold = 1'b1;
        batches++;
    endtask

    task automatic model_reset();
        q.delete();
        m_hold = 1'b0;
    endtask

    // Called just after a rising edge: drive, check, advance model, wait.
    task automatic cycle(input bit v, input int s, input bit ordy, input bit fl);
        in_valid  = v;
        in_sum    = s[SUM_W-1:0];
        out_ready = ordy;
        flush     = fl;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_hold});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
        if (m_hold) begin
            chk("model_total", 32'(out_total), m_total);
            chk("model_max", 32'(out_max), m_max);
            chk("model_idx", 32'(out_max_idx), m_idx);
        end
        if (fl) begin
            model_reset();
        end else if (!m_hold) begin
            if (v) begin
                q.push_back(s);
                if (q.size() == COUNT) finish_batch();
            end
        end else if (ordy) begin
            m_hold = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input int t, input int m, input int idx);
        chk("res_valid", {31'd0, out_valid}, 32'd1);
        chk("res_total", 32'(out_total), t);
        chk("res_max", 32'(out_max), m);
        chk("res_idx", 32'(out_max_idx), idx);
    endtask

    initial begin
        int seq3[8];
        int cyc;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;
        batches   = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_total", 32'(out_total), 32'd0);
        chk("rst_max", 32'(out_max), 32'd0);
        chk("rst_idx", 32'(out_max_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ascending batch.
        for (int i = 1; i <= 8; i++) cycle(1, i, 1, 0);
        check_result(36, 8, 7);
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        cycle(0, 0, 1, 0);

        // All-max batch: no overflow, tie keeps index 0.
        for (int i = 0; i < 8; i++) cycle(1, 31, 1, 0);
        check_result(248, 31, 0);
        cycle(0, 0, 1, 0);

        // Stalled consumer with upstream pushing during HOLD.
        seq3 = '{3, 9, 9, 2, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) cycle(1, seq3[i], 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 17, 0, 0);
        check_result(23, 9, 1);
        cycle(1, 17, 1, 0);
        for (int i = 0; i < 8; i++) cycle(1, 1, 1, 0);
        check_result(8, 1, 0);
        cycle(0, 0, 1, 0);

        // Flush mid-batch with a same-cycle sample.
        for (int i = 0; i < 4; i++) cycle(1, 5, 1, 0);
        cycle(1, 20, 1, 1);
        for (int i = 0; i < 8; i++) cycle(1, 2, 1, 0);
        check_result(16, 2, 0);

        // Asynchronous reset while holding a result.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_total", 32'(out_total), 32'd0);
        #2;
        rst_n = 1'b1;
        model_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) cycle(1, 10 + i * 2 - (i % 3) * 5, 1, 0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        cycle(0, 0, 1, 0);

        // Randomized gaps on both sides of the block.
        batches = 0;
        cyc     = 0;
        while (batches < 100 && cyc < 20000) begin
            cycle(($urandom & 1) == 1, int'($urandom_range(0, 31)),
                  ($urandom & 1) == 1, $urandom_range(0, 199) == 0);
            cyc++;
        end
        chk("random_batches_done", 32'(batches >= 100), 32'd1);
        cycle(0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
